// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared constants and fetch-state encoding
// Ports: none (package). Provides WORD_SIZE, PC_INITIAL, NOP_INSTR, timeout
// sizing and the FS_* state encoding used by the sequencer FSM.
package fetch_sequencer_pkg;

  localparam int                   WORD_SIZE      = 32;
  localparam logic [WORD_SIZE-1:0] PC_INITIAL     = 32'h0000_0000;
  localparam logic [WORD_SIZE-1:0] NOP_INSTR      = 32'h0000_0013;
  localparam int                   TIMEOUT_CYCLES = 64;
  localparam int                   CNT_W          = 7;

  localparam logic [2:0] FS_IDLE  = 3'd0;
  localparam logic [2:0] FS_REQ   = 3'd1;
  localparam logic [2:0] FS_WAIT  = 3'd2;
  localparam logic [2:0] FS_VALID = 3'd3;
  localparam logic [2:0] FS_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = FS_IDLE,
    ST_REQ   = FS_REQ,
    ST_WAIT  = FS_WAIT,
    ST_VALID = FS_VALID,
    ST_DRAIN = FS_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory request/response bus
// Ports (signals): mem_req, mem_addr (requester -> memory);
// mem_gnt, mem_rvalid, mem_rdata (memory -> requester).
// Modports: master = fetch sequencer side, slave = memory side.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - saturating wait counter with sticky expiry flag
// Ports: clk, rst (sync, active-high); clear (restart count), enable (count
// this cycle); expired (high from the cycle the count reaches LIMIT-1, then
// sticky until rst).
module fetch_timeout_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES,
  parameter int WIDTH = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;
  logic             expiredSticky;
  logic             atLimit;

  assign atLimit = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      expiredSticky <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (enable && !atLimit) begin
        count <= count + WIDTH'(1);
      end
      if (atLimit) begin
        expiredSticky <= 1'b1;
      end
    end
  end

  // The flag shows in the very cycle the limit is reached; the sticky bit
  // keeps it after the count is cleared by a later state change.
  assign expired = expiredSticky | atLimit;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch sequencer
// Ports: clk, rst (sync, active-high); PCF (current PC), PCSrcE (redirect),
// StallD (decode busy); mem (fetch_sequencer_if.master: req/addr out,
// gnt/rvalid/rdata in); InstrF, instr_valid toward F/D; pc_advance and
// bubble_d toward the hazard unit; fetch_error (sticky timeout).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYCLES,
  parameter int CW      = CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] PCF,
  input  logic                 PCSrcE,
  input  logic                 StallD,
  fetch_sequencer_if.master    mem,
  output logic [WORD_SIZE-1:0] InstrF,
  output logic                 instr_valid,
  output logic                 pc_advance,
  output logic                 bubble_d,
  output logic                 fetch_error
);

  fetch_state_t state;
  fetch_state_t stateNext;
  logic         captureInstr;
  logic         releaseInstr;
  logic         grantSinceRst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    mem.mem_req  = 1'b0;
    instr_valid  = 1'b0;
    pc_advance   = 1'b0;
    captureInstr = 1'b0;
    releaseInstr = 1'b0;
    unique case (state)
      ST_IDLE: stateNext = ST_REQ;
      ST_REQ: begin
        mem.mem_req = 1'b1;
        // Without a grant the request simply repeats with whatever PC is
        // presented, so a redirect needs no special handling here.
        if (mem.mem_gnt) begin
          stateNext = PCSrcE ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          captureInstr = !PCSrcE;
          stateNext    = PCSrcE ? ST_REQ : ST_VALID;
        end else if (PCSrcE) begin
          stateNext = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Response belongs to the pre-redirect PC; swallow it.
        if (mem.mem_rvalid) begin
          stateNext = ST_REQ;
        end
      end
      ST_VALID: begin
        instr_valid = 1'b1;
        pc_advance  = !StallD && !PCSrcE;
        if (pc_advance || PCSrcE) begin
          releaseInstr = 1'b1;
          stateNext    = ST_REQ;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign mem.mem_addr = PCF;
  assign bubble_d     = !instr_valid || PCSrcE;

  always_ff @(posedge clk) begin
    if (rst) begin
      InstrF <= NOP_INSTR;
    end else if (captureInstr) begin
      InstrF <= mem.mem_rdata;
    end else if (releaseInstr) begin
      InstrF <= NOP_INSTR;
    end
  end

  fetch_timeout_counter #(
    .LIMIT (TIMEOUT),
    .WIDTH (CW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (stateNext != state),
    .enable  ((state == ST_REQ) || (state == ST_WAIT)),
    .expired (fetch_error)
  );

  // Until the first grant after reset, a response can only be the tail of a
  // request killed by reset, so it is tolerated; afterwards a response
  // outside WAIT/DRAIN is a memory protocol violation.
  always_ff @(posedge clk) begin
    if (rst) begin
      grantSinceRst <= 1'b0;
    end else if (mem.mem_req && mem.mem_gnt) begin
      grantSinceRst <= 1'b1;
    end
  end

  rvalid_window_chk : assert property (@(posedge clk) disable iff (rst)
    mem.mem_rvalid |-> ((state == ST_WAIT) || (state == ST_DRAIN) || !grantSinceRst));

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
// Ports: none (top-level bench). Drives PCF/PCSrcE/StallD and the memory
// side of fetch_sequencer_if; checks outputs on the falling clock edge.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WORD_SIZE-1:0] PCF;
  logic                 PCSrcE;
  logic                 StallD;
  logic [WORD_SIZE-1:0] InstrF;
  logic                 instr_valid;
  logic                 pc_advance;
  logic                 bubble_d;
  logic                 fetch_error;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [31:0] expQ[$];

  fetch_sequencer_if memBus ();

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .PCSrcE      (PCSrcE),
    .StallD      (StallD),
    .mem         (memBus),
    .InstrF      (InstrF),
    .instr_valid (instr_valid),
    .pc_advance  (pc_advance),
    .bubble_d    (bubble_d),
    .fetch_error (fetch_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply this cycle's inputs, then move to the sampling point.
  task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic src, input logic stall);
    memBus.mem_gnt    = gnt;
    memBus.mem_rvalid = rvalid;
    memBus.mem_rdata  = rdata;
    PCSrcE            = src;
    StallD            = stall;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectConsume(input string tag);
    logic [31:0] want;
    check({tag, "_valid"}, instr_valid, 1'b1);
    check({tag, "_adv"}, pc_advance, 1'b1);
    check({tag, "_sbdepth"}, expQ.size() > 0, 1'b1);
    if (expQ.size() > 0) begin
      want = expQ.pop_front();
      check({tag, "_instr"}, InstrF, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    PCF = 32'h0000_0100;
    PCSrcE = 1'b0;
    StallD = 1'b0;
    memBus.mem_gnt = 1'b0;
    memBus.mem_rvalid = 1'b0;
    memBus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req", memBus.mem_req, 1'b0);
    check("rst_addr", memBus.mem_addr, PCF);
    check("rst_instr", InstrF, NOP_INSTR);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_adv", pc_advance, 1'b0);
    check("rst_bubble", bubble_d, 1'b1);
    check("rst_err", fetch_error, 1'b0);
    nextCycle();
    rst = 1'b0;

    // zero-wait fetch: IDLE, REQ, WAIT, VALID
    drive(0, 0, 0, 0, 0);
    check("t1_idle_req", memBus.mem_req, 1'b0);
    nextCycle();
    drive(1, 0, 0, 0, 0);
    check("t1_req", memBus.mem_req, 1'b1);
    check("t1_addr", memBus.mem_addr, 32'h0000_0100);
    nextCycle();
    expQ.push_back(32'h0050_0093);
    drive(0, 1, 32'h0050_0093, 0, 0);
    check("t1_wait_req", memBus.mem_req, 1'b0);
    check("t1_wait_valid", instr_valid, 1'b0);
    check("t1_wait_bubble", bubble_d, 1'b1);
    nextCycle();
    drive(0, 0, 0, 0, 0);
    expectConsume("t1");
    check("t1_bubble", bubble_d, 1'b0);
    nextCycle();
    PCF = PCF + 32'd4;
    drive(1, 0, 0, 0, 0);
    check("t1_one_pulse", pc_advance, 1'b0);
    check("t1_rereq", memBus.mem_req, 1'b1);
    check("t1_addr2", memBus.mem_addr, 32'h0000_0104);
    check("t1_nop", InstrF, NOP_INSTR);
    nextCycle();

    // decode stall while holding an instruction
    expQ.push_back(32'h00a0_0113);
    drive(0, 1, 32'h00a0_0113, 0, 1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      check("t2_hold", InstrF, expQ[0]);
      check("t2_noadv", pc_advance, 1'b0);
      check("t2_noreq", memBus.mem_req, 1'b0);
      check("t2_valid", instr_valid, 1'b1);
      nextCycle();
    end
    drive(0, 0, 0, 0, 0);
    expectConsume("t2");
    nextCycle();
    PCF = PCF + 32'd4;
    drive(1, 0, 0, 0, 0);
    check("t2_req", memBus.mem_req, 1'b1);
    nextCycle();

    // redirect in WAIT, stale response two cycles later
    drive(0, 0, 0, 1, 0);
    check("t3_bubble", bubble_d, 1'b1);
    check("t3_wait_req", memBus.mem_req, 1'b0);
    nextCycle();
    PCF = 32'h0000_0200;
    drive(0, 0, 0, 0, 0);
    check("t3_state", dut.state, FS_DRAIN);
    check("t3_drain_req", memBus.mem_req, 1'b0);
    check("t3_drain_valid", instr_valid, 1'b0);
    nextCycle();
    drive(0, 1, 32'hDEAD_BEEF, 0, 0);
    check("t3_rv_req", memBus.mem_req, 1'b0);
    check("t3_rv_valid", instr_valid, 1'b0);
    nextCycle();
    drive(1, 0, 0, 0, 0);
    check("t3_rereq", memBus.mem_req, 1'b1);
    check("t3_addr", memBus.mem_addr, 32'h0000_0200);
    check("t3_nop", InstrF, NOP_INSTR);
    check("t3_valid", instr_valid, 1'b0);
    nextCycle();

    // redirect and response in the same WAIT cycle
    drive(0, 1, 32'h0BAD_0BAD, 1, 0);
    check("t4_bubble_wait", bubble_d, 1'b1);
    check("t4_valid", instr_valid, 1'b0);
    nextCycle();
    PCF = 32'h0000_0300;
    drive(0, 0, 0, 0, 0);
    check("t4_req", memBus.mem_req, 1'b1);
    check("t4_bubble_req", bubble_d, 1'b1);
    check("t4_nop", InstrF, NOP_INSTR);
    check("t4_addr", memBus.mem_addr, 32'h0000_0300);
    check("t5_err_c1", fetch_error, 1'b0);
    nextCycle();

    // grant withheld: error rises on the 64th REQ cycle
    for (int i = 2; i <= 64; i++) begin
      drive(0, 0, 0, 0, 0);
      check("t5_err", fetch_error, (i == 64));
      if (i == 64) check("t5_still_req", memBus.mem_req, 1'b1);
      nextCycle();
    end
    drive(1, 0, 0, 0, 0);
    check("t5_err_gnt", fetch_error, 1'b1);
    nextCycle();
    expQ.push_back(32'h1234_5678);
    drive(0, 1, 32'h1234_5678, 0, 0);
    check("t5_err_wait", fetch_error, 1'b1);
    nextCycle();
    drive(0, 0, 0, 0, 0);
    expectConsume("t5");
    check("t5_err_valid", fetch_error, 1'b1);
    nextCycle();
    PCF = PCF + 32'd4;
    drive(1, 0, 0, 0, 0);
    check("t5_err_sticky", fetch_error, 1'b1);
    check("t5_rereq", memBus.mem_req, 1'b1);
    nextCycle();

    // reset during WAIT, stale response right after release
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    check("t6_wait_req", memBus.mem_req, 1'b0);
    nextCycle();
    rst = 1'b0;
    PCF = PC_INITIAL;
    drive(0, 1, 32'hCAFE_BABE, 0, 0);
    check("t6_err_clr", fetch_error, 1'b0);
    check("t6_idle_nop", InstrF, NOP_INSTR);
    check("t6_idle_req", memBus.mem_req, 1'b0);
    check("t6_idle_valid", instr_valid, 1'b0);
    nextCycle();
    drive(1, 0, 0, 0, 0);
    check("t6_req", memBus.mem_req, 1'b1);
    check("t6_req_nop", InstrF, NOP_INSTR);
    check("t6_req_valid", instr_valid, 1'b0);
    check("t6_addr", memBus.mem_addr, PC_INITIAL);
    nextCycle();
    expQ.push_back(32'h0010_0073);
    drive(0, 1, 32'h0010_0073, 0, 0);
    nextCycle();
    drive(0, 0, 0, 0, 0);
    expectConsume("t6");
    nextCycle();
    drive(0, 0, 0, 0, 0);
    check("sb_drained", expQ.size(), 0);
    check("t6_err_final", fetch_error, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
